// File: rtl/bsg_axil_csr_responder.sv
// AXI4-Lite responder that terminates AW/W/B/AR/R in a bank of read/write CSRs.
// Optional: define BSG_AXIL_CSR_PROT_CHECK_EN to reject unprivileged (awprot[0]=0) writes.
module bsg_axil_csr_responder
  #(parameter int addr_width_p = 32
    , parameter int data_width_p = 32
    , parameter int num_regs_p   = 4
    , parameter int base_addr_p  = 0)
   (input  logic                               clk_i
    , input  logic                             reset_i
    , input  logic [addr_width_p-1:0]          awaddr_i
    , input  logic [2:0]                       awprot_i
    , input  logic                             awvalid_i
    , output logic                             awready_o
    , input  logic [data_width_p-1:0]          wdata_i
    , input  logic [data_width_p/8-1:0]        wstrb_i
    , input  logic                             wvalid_i
    , output logic                             wready_o
    , output logic [1:0]                       bresp_o
    , output logic                             bvalid_o
    , input  logic                             bready_i
    , input  logic [addr_width_p-1:0]          araddr_i
    , input  logic [2:0]                       arprot_i
    , input  logic                             arvalid_i
    , output logic                             arready_o
    , output logic [data_width_p-1:0]          rdata_o
    , output logic [1:0]                       rresp_o
    , output logic                             rvalid_o
    , input  logic                             rready_i
    , output logic [num_regs_p*data_width_p-1:0] csr_o
    , output logic [num_regs_p-1:0]            csr_w_v_o
    );

    localparam int strb_w_lp   = data_width_p / 8;
    localparam int lg_bytes_lp = $clog2(strb_w_lp);
    localparam int idx_w_lp    = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
    localparam logic [addr_width_p-1:0] base_lp = addr_width_p'(base_addr_p);

    function automatic logic addr_ok(input logic [addr_width_p-1:0] a);
        logic [addr_width_p-1:0] off_idx;
        off_idx = (a - base_lp) >> lg_bytes_lp;
        return (a >= base_lp) && (off_idx < addr_width_p'(num_regs_p));
    endfunction

    function automatic logic [idx_w_lp-1:0] addr_idx(input logic [addr_width_p-1:0] a);
        logic [addr_width_p-1:0] off_idx;
        off_idx = (a - base_lp) >> lg_bytes_lp;
        return off_idx[idx_w_lp-1:0];
    endfunction

    logic [num_regs_p-1:0][data_width_p-1:0] csr_r;
    logic                      aw_v, w_v, b_v, r_v;
    logic [addr_width_p-1:0]   awaddr_r;
    logic [2:0]                awprot_r;
    logic [data_width_p-1:0]   wdata_r;
    logic [strb_w_lp-1:0]      wstrb_r;
    logic [1:0]                bresp_r, rresp_r;
    logic [data_width_p-1:0]   rdata_r;
    logic [num_regs_p-1:0]     csr_w_v_r;

    logic aw_hs, w_hs, ar_hs, r_hs, b_hs, commit, wr_addr_ok, wr_ok;
    logic [idx_w_lp-1:0] wr_idx;

    assign awready_o = ~aw_v & ~reset_i;
    assign wready_o  = ~w_v  & ~reset_i;
    assign arready_o = ~r_v  & ~reset_i;
    assign bvalid_o  = b_v   & ~reset_i;
    assign rvalid_o  = r_v   & ~reset_i;

    assign aw_hs = awvalid_i & awready_o;
    assign w_hs  = wvalid_i  & wready_o;
    assign ar_hs = arvalid_i & arready_o;
    assign r_hs  = rvalid_o  & rready_i;
    assign b_hs  = bvalid_o  & bready_i;

    // A pending B response stalls the next commit until it is being accepted.
    assign commit     = aw_v & w_v & (~b_v | bready_i);
    assign wr_addr_ok = addr_ok(awaddr_r);
    assign wr_idx     = addr_idx(awaddr_r);
`ifdef BSG_AXIL_CSR_PROT_CHECK_EN
    assign wr_ok = wr_addr_ok & awprot_r[0];
`else
    assign wr_ok = wr_addr_ok;
`endif

    logic unused_prot;
    assign unused_prot = &{1'b0, arprot_i, awprot_r};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            csr_r     <= '0;
            aw_v      <= 1'b0;
            w_v       <= 1'b0;
            b_v       <= 1'b0;
            r_v       <= 1'b0;
            awaddr_r  <= '0;
            awprot_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bresp_r   <= '0;
            rresp_r   <= '0;
            rdata_r   <= '0;
            csr_w_v_r <= '0;
        end else begin
            if (aw_hs) begin
                awaddr_r <= awaddr_i;
                awprot_r <= awprot_i;
                aw_v     <= 1'b1;
            end else if (commit) begin
                aw_v <= 1'b0;
            end

            if (w_hs) begin
                wdata_r <= wdata_i;
                wstrb_r <= wstrb_i;
                w_v     <= 1'b1;
            end else if (commit) begin
                w_v <= 1'b0;
            end

            if (commit) begin
                b_v     <= 1'b1;
                bresp_r <= wr_ok ? 2'b00 : 2'b10;
                if (wr_ok) begin
                    for (int k = 0; k < strb_w_lp; k++)
                        if (wstrb_r[k])
                            csr_r[wr_idx][k*8 +: 8] <= wdata_r[k*8 +: 8];
                end
            end else if (b_hs) begin
                b_v <= 1'b0;
            end

            for (int i = 0; i < num_regs_p; i++)
                csr_w_v_r[i] <= commit & wr_ok & (wr_idx == idx_w_lp'(i));

            // Reads sample the pre-edge CSR value, so a same-edge commit is not visible.
            if (ar_hs) begin
                r_v     <= 1'b1;
                rresp_r <= addr_ok(araddr_i) ? 2'b00 : 2'b10;
                rdata_r <= addr_ok(araddr_i) ? csr_r[addr_idx(araddr_i)] : '0;
            end else if (r_hs) begin
                r_v <= 1'b0;
            end
        end
    end

    assign csr_o     = csr_r;
    assign csr_w_v_o = csr_w_v_r;
    assign bresp_o   = bresp_r;
    assign rresp_o   = rresp_r;
    assign rdata_o   = rdata_r;

endmodule

// File: tb/tb_bsg_axil_csr_responder.sv
// Bench for bsg_axil_csr_responder: directed AXI-Lite traffic, queue-level reference model
// checked every cycle, plus literal expectations on each transaction.
module tb_bsg_axil_csr_responder;

    localparam int NREGS = 4;

    logic clk = 1'b0;
    logic reset_i;
    logic [31:0] awaddr_i, wdata_i, araddr_i, rdata_o;
    logic [2:0] awprot_i, arprot_i;
    logic [3:0] wstrb_i, csr_w_v_o;
    logic awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
    logic arvalid_i, arready_o, rvalid_o, rready_i;
    logic [1:0] bresp_o, rresp_o;
    logic [127:0] csr_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_axil_csr_responder #(.addr_width_p(32), .data_width_p(32), .num_regs_p(NREGS), .base_addr_p(0)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .awaddr_i(awaddr_i), .awprot_i(awprot_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .araddr_i(araddr_i), .arprot_i(arprot_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .csr_o(csr_o), .csr_w_v_o(csr_w_v_o));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] addr; logic [2:0] prot; } aw_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_t;
    aw_t aw_q[$];
    w_t  w_q[$];
    logic [1:0] b_q[$];
    r_t  r_q[$];
    logic [31:0] mcsr[NREGS];
    logic [3:0] mpulse;
    bit rst_seen = 0;

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = mcsr[i];
        return f;
    endfunction

    function automatic r_t mread(input logic [31:0] a);
        r_t r;
        if (a / 4 < NREGS) begin r.data = mcsr[a / 4]; r.resp = 2'b00; end
        else begin r.data = 32'h0; r.resp = 2'b10; end
        return r;
    endfunction

    always @(negedge clk) begin : model
        bit awhs, whs, arhs, rpop, bpop, commit, ok;
        aw_t a;
        w_t w;
        if (rst_seen) begin
            chk("awready", awready_o, !reset_i && aw_q.size() == 0);
            chk("wready", wready_o, !reset_i && w_q.size() == 0);
            chk("arready", arready_o, !reset_i && r_q.size() == 0);
            chk("bvalid", bvalid_o, !reset_i && b_q.size() != 0);
            chk("rvalid", rvalid_o, !reset_i && r_q.size() != 0);
            if (!reset_i && b_q.size() != 0) chk("bresp", bresp_o, b_q[0]);
            if (!reset_i && r_q.size() != 0) begin
                chk("rdata", rdata_o, r_q[0].data);
                chk("rresp", rresp_o, r_q[0].resp);
            end
            chk("csr_o", csr_o, mflat());
            chk("csr_w_v_o", csr_w_v_o, mpulse);
        end
        if (reset_i === 1'b1) begin
            aw_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
            for (int i = 0; i < NREGS; i++) mcsr[i] = 32'h0;
            mpulse = 4'h0;
            rst_seen = 1;
        end else if (rst_seen) begin
            awhs   = awvalid_i && aw_q.size() == 0;
            whs    = wvalid_i && w_q.size() == 0;
            arhs   = arvalid_i && r_q.size() == 0;
            rpop   = rready_i && r_q.size() != 0;
            bpop   = bready_i && b_q.size() != 0;
            commit = aw_q.size() != 0 && w_q.size() != 0 && (b_q.size() == 0 || bready_i);
            mpulse = 4'h0;
            if (rpop) void'(r_q.pop_front());
            if (arhs) r_q.push_back(mread(araddr_i));
            if (bpop) void'(b_q.pop_front());
            if (commit) begin
                a = aw_q.pop_front();
                w = w_q.pop_front();
                ok = (a.addr / 4 < NREGS);
`ifdef BSG_AXIL_CSR_PROT_CHECK_EN
                ok = ok && a.prot[0];
`endif
                b_q.push_back(ok ? 2'b00 : 2'b10);
                if (ok) begin
                    for (int k = 0; k < 4; k++)
                        if (w.strb[k]) mcsr[a.addr / 4][k*8 +: 8] = w.data[k*8 +: 8];
                    mpulse[a.addr / 4] = 1'b1;
                end
            end
            if (awhs) aw_q.push_back('{addr: awaddr_i, prot: awprot_i});
            if (whs) w_q.push_back('{data: wdata_i, strb: wstrb_i});
        end
    end

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [31:0] addr, input logic [2:0] prot);
        int n = 0;
        awaddr_i = addr; awprot_i = prot; awvalid_i = 1'b1;
        @(negedge clk);
        while (!awready_o && n < 50) begin @(negedge clk); n++; end
        chk("aw_handshake", awready_o, 1'b1);
        @(posedge clk); #1;
        awvalid_i = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        wdata_i = data; wstrb_i = strb; wvalid_i = 1'b1;
        @(negedge clk);
        while (!wready_o && n < 50) begin @(negedge clk); n++; end
        chk("w_handshake", wready_o, 1'b1);
        @(posedge clk); #1;
        wvalid_i = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot, input int gap);
        fork
            send_aw(addr, prot);
            begin
                repeat (gap) begin @(posedge clk); #1; end
                send_w(data, strb);
            end
        join
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] pulse);
        int n = 0;
        @(negedge clk);
        while (!bvalid_o && n < 50) begin @(negedge clk); n++; end
        chk("b_arrives", bvalid_o, 1'b1);
        resp = bresp_o;
        pulse = csr_w_v_o;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        araddr_i = addr; arvalid_i = 1'b1;
        @(negedge clk);
        while (!arready_o && n < 50) begin @(negedge clk); n++; end
        chk("ar_handshake", arready_o, 1'b1);
        @(posedge clk); #1;
        arvalid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid_o && n < 50) begin @(negedge clk); n++; end
        chk("r_arrives", rvalid_o, 1'b1);
        data = rdata_o;
        resp = rresp_o;
        @(posedge clk); #1;
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [2:0] prot, input int gap,
                         output logic [1:0] resp, output logic [3:0] pulse);
        send_pair(addr, data, strb, prot, gap);
        wait_b(resp, pulse);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] data;

        reset_i = 1'b1;
        awaddr_i = '0; awprot_i = '0; awvalid_i = 1'b0;
        wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
        araddr_i = '0; arprot_i = '0; arvalid_i = 1'b0;
        bready_i = 1'b1; rready_i = 1'b1;

        // reset: everything idle and cleared
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready_o, 1'b0);
        chk("rst_bvalid", bvalid_o, 1'b0);
        chk("rst_csr", csr_o, 128'h0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_readies", {awready_o, wready_o, arready_o}, 3'b111);
        @(posedge clk); #1;

        // AW first, W three cycles later
        write(32'h8, 32'hDEADBEEF, 4'hF, 3'b001, 3, resp, pulse);
        chk("w1_bresp", resp, 2'b00);
        chk("w1_pulse", pulse, 4'b0100);
        chk("w1_csr2", csr_o[95:64], 32'hDEADBEEF);
        do_read(32'h8, data, resp);
        chk("r1_data", data, 32'hDEADBEEF);
        chk("r1_resp", resp, 2'b00);

        // partial strobe
        write(32'h8, 32'h12345678, 4'h3, 3'b001, 0, resp, pulse);
        chk("w2_bresp", resp, 2'b00);
        chk("w2_csr", csr_o, {32'h0, 32'hDEAD5678, 32'h0, 32'h0});

        // out-of-range address
        write(32'h20, 32'hFFFFFFFF, 4'hF, 3'b001, 0, resp, pulse);
        chk("w3_bresp", resp, 2'b10);
        chk("w3_pulse", pulse, 4'b0000);
        chk("w3_csr", csr_o, {32'h0, 32'hDEAD5678, 32'h0, 32'h0});
        do_read(32'h20, data, resp);
        chk("r3_data", data, 32'h0);
        chk("r3_resp", resp, 2'b10);

        // B back-pressure with a second pair buffered behind it
        bready_i = 1'b0;
        write(32'h0, 32'hA5A5A5A5, 4'hF, 3'b001, 0, resp, pulse);
        chk("w4_csr0", csr_o[31:0], 32'hA5A5A5A5);
        send_pair(32'h4, 32'h11112222, 4'hF, 3'b001, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid", bvalid_o, 1'b1);
            chk("stall_bresp", bresp_o, 2'b00);
            chk("stall_csr1", csr_o[63:32], 32'h0);
            @(posedge clk); #1;
        end
        bready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_csr1", csr_o[63:32], 32'h11112222);
        chk("release_pulse", csr_w_v_o, 4'b0010);
        chk("release_bvalid", bvalid_o, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // R back-pressure
        rready_i = 1'b0;
        do_read(32'h8, data, resp);
        chk("r5_data", data, 32'hDEAD5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rhold_arready", arready_o, 1'b0);
            chk("rhold_rdata", rdata_o, 32'hDEAD5678);
            @(posedge clk); #1;
        end
        rready_i = 1'b1;
        @(posedge clk); #1;

        // protection bit
        write(32'h0, 32'h0BADF00D, 4'hF, 3'b000, 0, resp, pulse);
`ifdef BSG_AXIL_CSR_PROT_CHECK_EN
        chk("prot0_bresp", resp, 2'b10);
        chk("prot0_csr0", csr_o[31:0], 32'hA5A5A5A5);
`else
        chk("prot0_bresp", resp, 2'b00);
        chk("prot0_csr0", csr_o[31:0], 32'h0BADF00D);
`endif
        write(32'h0, 32'hCAFE0001, 4'hF, 3'b001, 0, resp, pulse);
        chk("prot1_bresp", resp, 2'b00);
        chk("prot1_csr0", csr_o[31:0], 32'hCAFE0001);

        // zero strobe still pulses; low address bits ignored
        write(32'hC, 32'hFFFFFFFF, 4'h0, 3'b001, 1, resp, pulse);
        chk("zstrb_bresp", resp, 2'b00);
        chk("zstrb_pulse", pulse, 4'b1000);
        chk("zstrb_csr3", csr_o[127:96], 32'h0);
        write(32'hE, 32'h33334444, 4'hF, 3'b001, 0, resp, pulse);
        chk("lowbits_csr3", csr_o[127:96], 32'h33334444);

        // reset with an AW buffered
        send_aw(32'h4, 3'b001);
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("midrst_csr", csr_o, 128'h0);
        chk("midrst_readies", {awready_o, wready_o, bvalid_o}, 3'b110);
        @(posedge clk); #1;
        write(32'h4, 32'h55AA55AA, 4'hF, 3'b001, 0, resp, pulse);
        chk("after_rst_pulse", pulse, 4'b0010);
        do_read(32'h4, data, resp);
        chk("after_rst_read", data, 32'h55AA55AA);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_axil_csr_responder.md
Name: bsg_axil_csr_responder

Overview:
- AXI4-Lite subordinate (responder): the far end of a DPI-driven AXI-Lite initiator.
- Terminates AW/W/B/AR/R in a bank of num_regs_p read/write CSRs, each data_width_p wide.
- Exposes the CSR contents and per-register write strobes to surrounding fabric logic.
- Used in cosim and FPGA shells to give host software a register window into the design.

Parameters:
- addr_width_p, 32, AXI-Lite address width.
- data_width_p, 32, data width; a multiple of 8, either 32 or 64.
- num_regs_p, 4, number of CSRs; at least 1.
- base_addr_p, 0, byte address of CSR 0; aligned to data_width_p/8.

Ports:
- clk_i  in  1  clock; all AXI channels are synchronous to it.
- reset_i  in  1  synchronous, active-high reset.
- awaddr_i  in  addr_width_p  write address.
- awprot_i  in  3  write protection.
- awvalid_i / awready_o  in/out  1  AW handshake.
- wdata_i  in  data_width_p  write data.
- wstrb_i  in  data_width_p/8  byte strobes.
- wvalid_i / wready_o  in/out  1  W handshake.
- bresp_o  out  2  write response.
- bvalid_o / bready_i  out/in  1  B handshake.
- araddr_i  in  addr_width_p  read address.
- arprot_i  in  3  read protection; ignored.
- arvalid_i / arready_o  in/out  1  AR handshake.
- rdata_o  out  data_width_p  read data.
- rresp_o  out  2  read response.
- rvalid_o / rready_i  out/in  1  R handshake.
- csr_o  out  num_regs_p*data_width_p  flattened CSR contents; CSR i occupies bits [i*data_width_p +: data_width_p].
- csr_w_v_o  out  num_regs_p  one-cycle pulse per CSR on write commit.

Behaviour:
- Reset: all CSRs cleared to 0. Internal state cleared: aw_v, w_v, b_v, r_v. bresp_o=0, rresp_o=0, rdata_o=0, csr_w_v_o=0.
- While reset_i=1: awready_o, wready_o, arready_o, bvalid_o, rvalid_o are forced 0.
- Address decode: offset = addr - base_addr_p; index = offset >> log2(data_width_p/8); low offset bits are ignored.
- Valid iff addr >= base_addr_p and index < num_regs_p; otherwise the access gets SLVERR (2'b10).
- AW buffer: awready_o = ~aw_v. On handshake, latch awaddr/awprot and set aw_v.
- W buffer: wready_o = ~w_v. On handshake, latch wdata/wstrb and set w_v.
- AW and W are independent; either may arrive first, any number of cycles apart, or in the same cycle.
- Write commit fires on an edge where aw_v & w_v & (~b_v | bready_i). At that edge:
  - Valid address: each byte k with wstrb[k]=1 replaces byte k of CSR[index]; other bytes are kept. csr_w_v_o[index] is 1 in the following cycle only. bresp_o=2'b00.
  - Invalid address: no CSR change, no pulse, bresp_o=2'b10.
  - b_v is set; aw_v and w_v are cleared.
  - A commit with all-zero wstrb still pulses csr_w_v_o and returns OKAY.
- B: bvalid_o = b_v. b_v is cleared on bvalid_o & bready_i unless a commit sets it again in the same edge. bresp_o is stable while bvalid_o=1.
- Write latency: with both handshakes at edge N, commit occurs at edge N+1 and bvalid_o rises after N+1.
- Write throughput: while b_v is set and bready_i=0, a second AW/W pair may be buffered, but its commit stalls.
- Read: arready_o = ~r_v. On an AR handshake, rdata_o/rresp_o are loaded from the pre-edge CSR value and r_v is set.
  - Invalid read address: rdata_o=0, rresp_o=2'b10.
  - r_v is cleared on rvalid_o & rready_i. rdata_o/rresp_o are stable while rvalid_o=1.
  - Read throughput: at most one read every 2 cycles.
- Simultaneous read and write commit to the same CSR on one edge: the read returns the old value.
- Read and write paths are fully independent; there is no ordering between them.
- Reset mid-transaction: buffered AW/W and pending B/R are discarded, and CSRs are cleared.

Optional Feature:
- Macro: BSG_AXIL_CSR_PROT_CHECK_EN.
- When defined: a committed write with awprot[0]=0 (unprivileged) to a valid address is rejected. Response is bresp_o=2'b10; the CSR is unchanged and there is no csr_w_v_o pulse.
- When undefined: awprot is latched but ignored, and all valid-address writes succeed.

Test Plan:
- Reset sequence -> all csr_o=0, all valid outputs 0. One cycle after reset_i falls: awready_o=wready_o=arready_o=1.
- AW 0x8, then W 0xDEADBEEF with strb 0xF three cycles later, bready_i=1 -> CSR2=0xDEADBEEF, csr_w_v_o=4'b0100 for one cycle, bresp_o=0. Read of 0x8 -> rdata_o=0xDEADBEEF, rresp_o=0.
- Then write 0x8 data 0x12345678 strb 0x3 -> CSR2=0xDEAD5678; CSR0, CSR1 and CSR3 unchanged.
- Write 0x20 with num_regs_p=4 -> bresp_o=2'b10, no pulse, csr_o unchanged. Read 0x20 -> rdata_o=0, rresp_o=2'b10.
- Hold bready_i=0 for 5 cycles with a second AW/W pair to 0x4 -> bvalid_o stays high, bresp_o stable, the second pair is accepted but CSR1 is unchanged. On release, CSR1 commits on the next edge. Hold rready_i=0 -> arready_o=0 and rdata_o stable.
- Macro defined, write 0x0 with awprot=3'b000 -> bresp_o=2'b10, CSR0 unchanged. Same write with awprot=3'b001 -> OKAY and CSR0 updated. Macro undefined -> both writes OKAY.
